// File: rtl/wb_pkg.sv
// Shared definitions for the writeback/commit stage and the difftest harness.
package wb_pkg;

  localparam int unsigned LANES_DEF     = 2;
  localparam int unsigned REG_IDX_W_DEF = 5;
  localparam int unsigned XLEN_DEF      = 32;
  localparam int unsigned CNT_W_DEF     = 64;
  localparam int unsigned PC_W          = 32;

  // Trap cause held in the sticky trap register.
  localparam logic [1:0] TRAP_NONE = 2'd0;
  localparam logic [1:0] TRAP_HALT = 2'd1;

  // One lane of the commit trace as seen by the difftest wrapper.
  typedef struct packed {
    logic                     valid;
    logic                     wen;
    logic [REG_IDX_W_DEF-1:0] wdest;
    logic [XLEN_DEF-1:0]      wdata;
    logic [PC_W-1:0]          pc;
  } cmt_rec_t;

  // Lane-field slicing for the default lane geometry.
  function automatic logic [REG_IDX_W_DEF-1:0] lane_rd(
    input logic [LANES_DEF*REG_IDX_W_DEF-1:0] v, input int unsigned k);
    return v[k*REG_IDX_W_DEF +: REG_IDX_W_DEF];
  endfunction

  function automatic logic [XLEN_DEF-1:0] lane_data(
    input logic [LANES_DEF*XLEN_DEF-1:0] v, input int unsigned k);
    return v[k*XLEN_DEF +: XLEN_DEF];
  endfunction

  function automatic logic [PC_W-1:0] lane_pc(
    input logic [LANES_DEF*PC_W-1:0] v, input int unsigned k);
    return v[k*PC_W +: PC_W];
  endfunction

endpackage

// File: rtl/writeback_commit_mask.sv
// Intra-group hazard resolution: which lanes commit and which regfile writes survive.
module writeback_commit_mask
  import wb_pkg::*;
#(
  parameter int unsigned LANES     = LANES_DEF,
  parameter int unsigned REG_IDX_W = REG_IDX_W_DEF
) (
  input  logic                       fire,
  input  logic [LANES-1:0]           r_valid,
  input  logic [LANES-1:0]           r_excp,
  input  logic [LANES-1:0]           r_halt,
  input  logic [LANES-1:0]           r_we,
  input  logic [LANES*REG_IDX_W-1:0] r_rd,
  output logic [LANES-1:0]           live,
  output logic [LANES-1:0]           ret,
  output logic [LANES-1:0]           reg_we
);

  logic blocked;
  logic shadowed;

  // Live lanes stop after the oldest excepting/halting lane; younger same-rd writes shadow older ones.
  always_comb begin
    live     = '0;
    ret      = '0;
    reg_we   = '0;
    blocked  = 1'b0;
    shadowed = 1'b0;
    for (int unsigned k = 0; k < LANES; k++) begin
      live[k] = fire & r_valid[k] & ~blocked;
      if (r_valid[k] & (r_excp[k] | r_halt[k])) blocked = 1'b1;
      ret[k] = live[k] & ~r_excp[k];
    end
    for (int unsigned k = 0; k < LANES; k++) begin
      shadowed = 1'b0;
      for (int unsigned j = k + 1; j < LANES; j++) begin
        if (ret[j] & r_we[j] &
            (r_rd[j*REG_IDX_W +: REG_IDX_W] == r_rd[k*REG_IDX_W +: REG_IDX_W]))
          shadowed = 1'b1;
      end
      reg_we[k] = ret[k] & r_we[k] & (r_rd[k*REG_IDX_W +: REG_IDX_W] != '0) & ~shadowed;
    end
  end

endmodule

// File: rtl/writeback_multi.sv
// N-lane writeback/commit stage with counters, sticky halt trap and commit trace.
module writeback_multi
  import wb_pkg::*;
#(
  parameter int unsigned LANES     = LANES_DEF,
  parameter int unsigned REG_IDX_W = REG_IDX_W_DEF,
  parameter int unsigned XLEN      = XLEN_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       stall_i,
  output logic                       stall_o,
  input  logic [LANES-1:0]           in_valid,
  input  logic [LANES-1:0]           in_we,
  input  logic [LANES*REG_IDX_W-1:0] in_rd,
  input  logic [LANES*XLEN-1:0]      in_wdata,
  input  logic [LANES*PC_W-1:0]      in_pc,
  input  logic [LANES-1:0]           in_excp,
  input  logic [LANES-1:0]           in_halt,
  output logic [LANES-1:0]           reg_we,
  output logic [LANES*REG_IDX_W-1:0] reg_idx,
  output logic [LANES*XLEN-1:0]      reg_data,
  output logic [LANES-1:0]           cmt_valid,
  output logic [LANES-1:0]           cmt_wen,
  output logic [LANES*REG_IDX_W-1:0] cmt_wdest,
  output logic [LANES*XLEN-1:0]      cmt_wdata,
  output logic [LANES*PC_W-1:0]      cmt_pc,
  output logic                       cmt_excp,
  output logic                       trap,
  output logic [PC_W-1:0]            trap_pc,
  output logic [CNT_W-1:0]           cycle_cnt,
  output logic [CNT_W-1:0]           instr_cnt
);

  logic [LANES-1:0]           r_valid;
  logic [LANES-1:0]           r_we;
  logic [LANES*REG_IDX_W-1:0] r_rd;
  logic [LANES*XLEN-1:0]      r_wdata;
  logic [LANES*PC_W-1:0]      r_pc;
  logic [LANES-1:0]           r_excp;
  logic [LANES-1:0]           r_halt;

  logic [1:0]       trap_code;
  logic             fire;
  logic [LANES-1:0] live;
  logic [LANES-1:0] ret;
  logic             halt_hit;
  logic [PC_W-1:0]  halt_pc;
  logic [CNT_W-1:0] ret_cnt;

  assign stall_o  = stall_i;
  assign trap     = (trap_code != TRAP_NONE);
  assign fire     = ~stall_i & ~trap;
  assign reg_idx  = r_rd;
  assign reg_data = r_wdata;

  // Stage register: flush empties the stage, otherwise load unless stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_we    <= '0;
      r_rd    <= '0;
      r_wdata <= '0;
      r_pc    <= '0;
      r_excp  <= '0;
      r_halt  <= '0;
    end else if (flush_i) begin
      r_valid <= '0;
    end else if (!stall_i) begin
      r_valid <= in_valid;
      r_we    <= in_we;
      r_rd    <= in_rd;
      r_wdata <= in_wdata;
      r_pc    <= in_pc;
      r_excp  <= in_excp;
      r_halt  <= in_halt;
    end
  end

  writeback_commit_mask #(
    .LANES     (LANES),
    .REG_IDX_W (REG_IDX_W)
  ) u_mask (
    .fire    (fire),
    .r_valid (r_valid),
    .r_excp  (r_excp),
    .r_halt  (r_halt),
    .r_we    (r_we),
    .r_rd    (r_rd),
    .live    (live),
    .ret     (ret),
    .reg_we  (reg_we)
  );

  // Retire count and PC of the (single possible) retiring halt lane.
  always_comb begin
    ret_cnt  = '0;
    halt_hit = 1'b0;
    halt_pc  = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      ret_cnt = ret_cnt + CNT_W'(ret[k]);
      if (!halt_hit && ret[k] && r_halt[k]) begin
        halt_hit = 1'b1;
        halt_pc  = r_pc[k*PC_W +: PC_W];
      end
    end
  end

  // Counters and sticky trap; counting stops once the trap is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
      trap_code <= TRAP_NONE;
      trap_pc   <= '0;
    end else begin
      if (!trap) cycle_cnt <= cycle_cnt + CNT_W'(1);
      instr_cnt <= instr_cnt + ret_cnt;
      if (halt_hit) begin
        trap_code <= TRAP_HALT;
        trap_pc   <= halt_pc;
      end
    end
  end

  // Registered commit trace for the difftest harness.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmt_valid <= '0;
      cmt_wen   <= '0;
      cmt_wdest <= '0;
      cmt_wdata <= '0;
      cmt_pc    <= '0;
      cmt_excp  <= 1'b0;
    end else begin
      cmt_valid <= live;
      cmt_wen   <= reg_we;
      cmt_wdest <= r_rd;
      cmt_wdata <= r_wdata;
      cmt_pc    <= r_pc;
      cmt_excp  <= |(live & r_excp);
    end
  end

endmodule

// File: tb/tb_writeback_multi.sv
// Scoreboard bench for writeback_multi: stimulus queues expected traces, a monitor checks them.
module tb_writeback_multi;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i, stall_i, stall_o;
  logic [1:0]  in_valid, in_we, in_excp, in_halt;
  logic [9:0]  in_rd;
  logic [63:0] in_wdata, in_pc;
  logic [1:0]  reg_we, cmt_valid, cmt_wen;
  logic [9:0]  reg_idx, cmt_wdest;
  logic [63:0] reg_data, cmt_wdata, cmt_pc;
  logic        cmt_excp, trap;
  logic [31:0] trap_pc;
  logic [63:0] cycle_cnt, instr_cnt;

  always #5 clk = ~clk;

  writeback_multi dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .stall_i(stall_i), .stall_o(stall_o),
    .in_valid(in_valid), .in_we(in_we), .in_rd(in_rd), .in_wdata(in_wdata), .in_pc(in_pc),
    .in_excp(in_excp), .in_halt(in_halt),
    .reg_we(reg_we), .reg_idx(reg_idx), .reg_data(reg_data),
    .cmt_valid(cmt_valid), .cmt_wen(cmt_wen), .cmt_wdest(cmt_wdest), .cmt_wdata(cmt_wdata),
    .cmt_pc(cmt_pc), .cmt_excp(cmt_excp), .trap(trap), .trap_pc(trap_pc),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  typedef struct packed {
    cmt_rec_t [1:0] lane;
    logic           excp;
    logic [63:0]    instr;
  } exp_t;

  exp_t        q[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [63:0] exp_instr;
  logic [63:0] tb_cyc;
  logic [63:0] frozen;

  // Independent cycle reference: edges seen since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cyc <= '0;
    else if (!trap) tb_cyc <= tb_cyc + 64'd1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every presented trace must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && cmt_valid != 2'b00) begin
      if (q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_trace: got cmt_valid=%b, expected no trace", cmt_valid);
      end else begin
        e = q.pop_front();
        chk("cmt_valid", 64'(cmt_valid), 64'({e.lane[1].valid, e.lane[0].valid}));
        chk("cmt_wen", 64'(cmt_wen), 64'({e.lane[1].wen, e.lane[0].wen}));
        chk("cmt_excp", 64'(cmt_excp), 64'(e.excp));
        chk("instr_cnt", instr_cnt, e.instr);
        for (int k = 0; k < 2; k++) begin
          chk("cmt_wdest", 64'(lane_rd(cmt_wdest, k)), 64'(e.lane[k].wdest));
          chk("cmt_wdata", 64'(lane_data(cmt_wdata, k)), 64'(e.lane[k].wdata));
          chk("cmt_pc", 64'(lane_pc(cmt_pc, k)), 64'(e.lane[k].pc));
        end
      end
    end
  end

  // Present one group for one capture edge; optionally queue its expected trace.
  task automatic group(input logic [1:0] v, we, ex, ht,
                       input logic [4:0] rd0, rd1, input logic [31:0] d0, d1, pc0, pc1,
                       input bit exp_trace, input logic [1:0] ev, ew, input logic ee,
                       input logic [63:0] ei);
    exp_t e;
    in_valid = v;  in_we = we;  in_excp = ex;  in_halt = ht;
    in_rd = {rd1, rd0};  in_wdata = {d1, d0};  in_pc = {pc1, pc0};
    if (exp_trace) begin
      e.lane[0].valid = ev[0]; e.lane[0].wen = ew[0]; e.lane[0].wdest = rd0;
      e.lane[0].wdata = d0;    e.lane[0].pc  = pc0;
      e.lane[1].valid = ev[1]; e.lane[1].wen = ew[1]; e.lane[1].wdest = rd1;
      e.lane[1].wdata = d1;    e.lane[1].pc  = pc1;
      e.excp  = ee;
      e.instr = ei;
      q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = '0;  in_we = '0;  in_excp = '0;  in_halt = '0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst_n = 1'b0;  flush_i = 1'b0;  stall_i = 1'b0;
    in_valid = '0; in_we = '0; in_excp = '0; in_halt = '0;
    in_rd = '0; in_wdata = '0; in_pc = '0;
    exp_instr = '0;
    tick(2);
    // Reset state
    chk("rst_reg_we", 64'(reg_we), 64'd0);
    chk("rst_cmt_valid", 64'(cmt_valid), 64'd0);
    chk("rst_trap", 64'(trap), 64'd0);
    chk("rst_trap_pc", 64'(trap_pc), 64'd0);
    chk("rst_instr_cnt", instr_cnt, 64'd0);
    chk("rst_cycle_cnt", cycle_cnt, 64'd0);
    rst_n = 1'b1;
    tick(3);
    chk("cycle_cnt_run", cycle_cnt, tb_cyc);

    // WAW: younger lane shadows the older write to x3
    exp_instr = 64'd2;
    group(2'b11, 2'b11, 2'b00, 2'b00, 5'd3, 5'd3, 32'h11, 32'h22, 32'h100, 32'h104,
          1'b1, 2'b11, 2'b10, 1'b0, exp_instr);
    chk("waw_reg_we", 64'(reg_we), 64'd2);
    chk("waw_reg_data1", 64'(reg_data[63:32]), 64'h22);
    chk("waw_reg_idx1", 64'(reg_idx[9:5]), 64'd3);

    // Exception on lane 0 kills lane 1
    group(2'b11, 2'b10, 2'b01, 2'b00, 5'd0, 5'd5, 32'h0, 32'h55, 32'h200, 32'h204,
          1'b1, 2'b01, 2'b00, 1'b1, exp_instr);
    chk("excp_reg_we", 64'(reg_we), 64'd0);

    // Write to x0 retires but does not write
    exp_instr = 64'd3;
    group(2'b01, 2'b01, 2'b00, 2'b00, 5'd0, 5'd0, 32'hFFFF, 32'h0, 32'h300, 32'h0,
          1'b1, 2'b01, 2'b00, 1'b0, exp_instr);
    chk("r0_reg_we", 64'(reg_we), 64'd0);

    // Independent writes both land
    exp_instr = 64'd5;
    group(2'b11, 2'b11, 2'b00, 2'b00, 5'd1, 5'd2, 32'hA1, 32'hB2, 32'h400, 32'h404,
          1'b1, 2'b11, 2'b11, 1'b0, exp_instr);
    chk("pair_reg_we", 64'(reg_we), 64'd3);

    // Excepting younger lane is live but does not shadow the older write
    exp_instr = 64'd6;
    group(2'b11, 2'b11, 2'b10, 2'b00, 5'd7, 5'd7, 32'hC7, 32'hD7, 32'h500, 32'h504,
          1'b1, 2'b11, 2'b01, 1'b1, exp_instr);
    chk("excp1_reg_we", 64'(reg_we), 64'd1);

    // Stall: held group commits exactly once on release
    exp_instr = 64'd8;
    group(2'b11, 2'b11, 2'b00, 2'b00, 5'd4, 5'd6, 32'h44, 32'h66, 32'h600, 32'h604,
          1'b1, 2'b11, 2'b11, 1'b0, exp_instr);
    stall_i = 1'b1;
    repeat (3) begin
      #1;
      chk("stall_reg_we", 64'(reg_we), 64'd0);
      chk("stall_o", 64'(stall_o), 64'd1);
      @(posedge clk); #1;
    end
    stall_i = 1'b0;
    #1;
    chk("release_reg_we", 64'(reg_we), 64'd3);
    tick(1);
    chk("post_release_reg_we", 64'(reg_we), 64'd0);

    // Flush together with stall empties the stage
    group(2'b11, 2'b11, 2'b00, 2'b00, 5'd9, 5'd10, 32'h99, 32'hAA, 32'h700, 32'h704,
          1'b0, 2'b00, 2'b00, 1'b0, 64'd0);
    stall_i = 1'b1;  flush_i = 1'b1;
    #1;
    chk("flush_stall_reg_we", 64'(reg_we), 64'd0);
    @(posedge clk); #1;
    stall_i = 1'b0;  flush_i = 1'b0;
    #1;
    chk("flush_empty_reg_we", 64'(reg_we), 64'd0);
    tick(2);
    chk("flush_instr_cnt", instr_cnt, exp_instr);

    // Halt on lane 0 traps, kills lane 1, freezes counters
    exp_instr = 64'd9;
    group(2'b11, 2'b10, 2'b00, 2'b01, 5'd0, 5'd5, 32'h0, 32'h55, 32'h1c000100, 32'h1c000104,
          1'b1, 2'b01, 2'b00, 1'b0, exp_instr);
    chk("halt_reg_we", 64'(reg_we), 64'd0);
    tick(1);
    chk("trap_set", 64'(trap), 64'd1);
    chk("trap_pc", 64'(trap_pc), 64'h1c000100);
    chk("trap_cycle_cnt", cycle_cnt, tb_cyc);
    frozen = tb_cyc;
    group(2'b11, 2'b11, 2'b00, 2'b00, 5'd1, 5'd2, 32'h1, 32'h2, 32'h800, 32'h804,
          1'b0, 2'b00, 2'b00, 1'b0, 64'd0);
    chk("trapped_reg_we", 64'(reg_we), 64'd0);
    tick(9);
    chk("frozen_cycle_cnt", cycle_cnt, frozen);
    chk("frozen_instr_cnt", instr_cnt, exp_instr);
    chk("trap_sticky", 64'(trap), 64'd1);

    // Reset pulse clears everything asynchronously
    rst_n = 1'b0;
    #2;
    chk("rst2_trap", 64'(trap), 64'd0);
    chk("rst2_trap_pc", 64'(trap_pc), 64'd0);
    chk("rst2_cycle_cnt", cycle_cnt, 64'd0);
    chk("rst2_instr_cnt", instr_cnt, 64'd0);
    rst_n = 1'b1;
    exp_instr = 64'd0;
    tick(1);

    // Reset mid-group drops the group with no partial commit
    group(2'b11, 2'b11, 2'b00, 2'b00, 5'd12, 5'd13, 32'hCC, 32'hDD, 32'h900, 32'h904,
          1'b0, 2'b00, 2'b00, 1'b0, 64'd0);
    chk("pre_rst_reg_we", 64'(reg_we), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_reg_we", 64'(reg_we), 64'd0);
    rst_n = 1'b1;
    tick(2);
    chk("mid_rst_instr_cnt", instr_cnt, 64'd0);

    // Normal operation resumes after reset
    exp_instr = 64'd2;
    group(2'b11, 2'b11, 2'b00, 2'b00, 5'd20, 5'd21, 32'h1234, 32'h5678, 32'hA00, 32'hA04,
          1'b1, 2'b11, 2'b11, 1'b0, exp_instr);
    tick(3);
    chk("final_cycle_cnt", cycle_cnt, tb_cyc);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
